result_bcd_converter: RTL
=========================

RESULT_BCD_CONVERTER -- requirements
Module: result_bcd_converter

Interface
REQ-001 Parameter: WORD_LENGTH, default 16, operand width of the upstream multiply/square-root unit; the result width is 2*WORD_LENGTH.
REQ-002 Port: clk  input  1  single clock for the block; all flops rise-edge triggered.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: ready  input  1  result-ready flag from the upstream arithmetic unit (level or pulse).
REQ-005 Port: Result  input  2*WORD_LENGTH  signed two's-complement result from the upstream unit.
REQ-006 Port: error  input  1  upstream error flag, sampled with Result.
REQ-007 Port: bcd  output  4*DIGITS  magnitude in packed BCD, digit 0 in bits [3:0].
REQ-008 Port: sign  output  1  1 = displayed value is negative.
REQ-009 Port: error_out  output  1  1 = captured result was flagged as an error.
REQ-010 Port: valid  output  1  one-cycle pulse; bcd/sign/error_out updated this cycle.
REQ-011 Port: busy  output  1  high from the capture edge until valid is asserted.

Function
REQ-012 The block SHALL detect a rising edge of ready (ready=1, registered ready_d=0) and act on it only in IDLE; in any other state the edge SHALL be dropped.
REQ-013 FSM states SHALL be IDLE, SHIFT and DONE; IDLE->SHIFT on an accepted edge with error=0; IDLE->DONE on an accepted edge with error=1; SHIFT->DONE when the shift count reaches 2*WORD_LENGTH; DONE->IDLE unconditionally.
REQ-014 On the capture edge the block SHALL latch sign_c=Result[MSB], err_c=error, and mag = sign_c ? (~Result+1) : Result as a 2*WORD_LENGTH-bit unsigned value, so that 0x8000_0000 yields mag 2^31.
REQ-015 On the capture edge the block SHALL clear the BCD working register and the shift counter.
REQ-016 Each SHIFT cycle SHALL add 3 to every working digit >= 5, then shift {bcd_work, mag} left by one bit (double dabble); exactly 2*WORD_LENGTH SHIFT cycles SHALL occur.
REQ-017 In DONE the block SHALL load bcd<=bcd_work, sign<=sign_c and error_out<=err_c, and assert valid for exactly one cycle.
REQ-018 Error path: bcd SHALL load all zeros, sign SHALL load 0 and error_out SHALL load 1.
REQ-019 Latency SHALL be valid 2*WORD_LENGTH+1 clocks after the capture edge on the normal path (33 for WORD_LENGTH=16) and 1 clock after it on the error path.
REQ-020 bcd, sign and error_out SHALL hold their previous values throughout SHIFT and change only in DONE.
REQ-021 busy SHALL be 1 in SHIFT and DONE and 0 in IDLE.
REQ-022 ready held high across several conversions SHALL trigger only one conversion; a new conversion requires ready to go low and then high again.
REQ-023 A ready edge coincident with the DONE cycle SHALL be dropped; ready_d SHALL still track ready in every state.

Reset
REQ-024 While reset=0 the block SHALL asynchronously force the FSM to IDLE and set bcd=0, sign=0, error_out=0, valid=0, busy=0, ready_d=0, and clear the counter and working registers.
REQ-025 Reset asserted mid-SHIFT SHALL abort the conversion with no valid pulse; after release the block SHALL be in IDLE, ready to accept an edge.

Structure
REQ-026 A shared package SHALL hold the FSM state enumeration and the constant DIGITS = ceil(2*WORD_LENGTH*log10(2)), tabulated as 5 for WORD_LENGTH=8 and 10 for WORD_LENGTH=16.
REQ-027 The package SHALL also hold the constant CNT_W = clog2(2*WORD_LENGTH+1).
REQ-028 A single sub-module, bcd_digit_adj (4-bit in, 4-bit out, +3 if >=5), SHALL be instantiated DIGITS times; everything else SHALL be flat.

Verification
REQ-029 Result=0x0000_3039, error=0, ready 0->1 -> busy=1, then valid after 33 clocks with bcd=0x0000012345, sign=0, error_out=0.
REQ-030 Result=0xFFFF_FFFF -> bcd=0x0000000001, sign=1; Result=0x8000_0000 -> bcd=0x2147483648, sign=1; Result=0 -> bcd=0, sign=0.
REQ-031 error=1 with Result=0x1234_5678, ready edge -> valid 1 clock later with error_out=1, bcd=0, sign=0, and no SHIFT cycles.
REQ-032 Second ready edge 10 clocks into a conversion, and ready held high for 100 clocks -> exactly one valid pulse each, with the result of the first capture.
REQ-033 reset=0 asserted at SHIFT count 15 -> all outputs 0 immediately and no valid pulse; after release, a new edge with Result=7 -> bcd=0x0000000007.
REQ-034 Back-to-back: edge in the DONE cycle dropped; edge 1 clock after DONE accepted with correct result.

Source files
------------

// File: rtl/result_bcd_converter_pkg.sv
// Shared types and sizing helpers for the signed-result to BCD converter.
package result_bcd_converter_pkg;

    // Conversion sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Operand width of the upstream arithmetic unit in its usual build.
    localparam int DEF_WORD_LENGTH = 16;

    // Decimal digits needed for a 2*wl-bit magnitude:
    // ceil(2*wl*log10(2)), with log10(2) approximated as 0.30103.
    // Yields 5 for wl=8 and 10 for wl=16.
    function automatic int digits_for(input int wl);
        return (2 * wl * 30103 + 99999) / 100000;
    endfunction

    // Width of a counter that must be able to hold the value 2*wl.
    function automatic int cnt_w_for(input int wl);
        return $clog2(2 * wl + 1);
    endfunction

    localparam int DIGITS = digits_for(DEF_WORD_LENGTH);
    localparam int CNT_W  = cnt_w_for(DEF_WORD_LENGTH);

endpackage

// File: rtl/result_bcd_converter_digit_adj.sv
// One double-dabble correction cell: a BCD digit of 5 or more gets +3 so
// that the following left shift carries correctly into the next digit.
module bcd_digit_adj (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    // Pure combinational correction, no state.
    always_comb begin
        if (digit_i >= 4'd5) begin
            digit_o = digit_i + 4'd3;
        end else begin
            digit_o = digit_i;
        end
    end

endmodule

// File: rtl/result_bcd_converter.sv
// Converts a signed two's-complement result into sign + packed BCD magnitude
// using a serial double-dabble engine (one bit per clock).
//
// Handshake: a conversion starts on a rising edge of ready seen while idle;
// Result and error are sampled on that same clock edge. busy is high from the
// capture edge until valid. valid is a single-cycle pulse marking the cycle
// in which bcd/sign/error_out take their new values; those outputs are
// otherwise held. Edges of ready arriving while busy are discarded.
module result_bcd_converter
    import result_bcd_converter_pkg::*;
#(
    parameter  int WORD_LENGTH = DEF_WORD_LENGTH,
    localparam int RW          = 2 * WORD_LENGTH,
    localparam int ND          = digits_for(WORD_LENGTH),
    localparam int CW          = cnt_w_for(WORD_LENGTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ready,
    input  logic [RW-1:0]   Result,
    input  logic            error,
    output logic [4*ND-1:0] bcd,
    output logic            sign,
    output logic            error_out,
    output logic            valid,
    output logic            busy,
    output logic [1:0]      dbg_state
);

    // Sequencer state.
    state_e state_q, state_d;

    // Previous ready level for edge detection; tracks ready in every state.
    logic ready_prev_q;

    // Captured operands and double-dabble working registers.
    logic            sign_c_q, sign_c_d;
    logic            err_c_q, err_c_d;
    logic [RW-1:0]   mag_q, mag_d;
    logic [4*ND-1:0] work_q, work_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    // Visible result registers.
    logic [4*ND-1:0] bcd_q, bcd_d;
    logic            sign_q, sign_d;
    logic            err_out_q, err_out_d;
    logic            valid_q;

    // Control decoded from the state.
    logic ready_rise;
    logic capture;
    logic do_shift;
    logic load_out;
    logic last_shift;

    // Digit-corrected working register feeding the shifter.
    logic [4*ND-1:0] work_adj;
    // Top bit shifted out of the BCD register; always zero because ND digits
    // cover the largest magnitude.
    logic            work_msb_unused;

    assign ready_rise      = ready & ~ready_prev_q;
    assign last_shift      = (cnt_q == CW'(RW - 1));
    assign work_msb_unused = work_adj[4*ND-1];

    // One correction cell per BCD digit.
    for (genvar g = 0; g < ND; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_i (work_q[4*g +: 4]),
            .digit_o (work_adj[4*g +: 4])
        );
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accept an edge only when idle, error skips shifting.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (ready_rise) begin
                    state_d = error ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (last_shift) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output/control decode from the current state.
    always_comb begin
        capture  = (state_q == ST_IDLE) && ready_rise;
        do_shift = (state_q == ST_SHIFT);
        load_out = (state_q == ST_DONE);
        busy     = (state_q != ST_IDLE);
    end

    // Datapath next-state: capture, shift-and-correct, and result load.
    always_comb begin
        sign_c_d  = sign_c_q;
        err_c_d   = err_c_q;
        mag_d     = mag_q;
        work_d    = work_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        sign_d    = sign_q;
        err_out_d = err_out_q;

        if (capture) begin
            sign_c_d = Result[RW-1];
            err_c_d  = error;
            // Negation in RW bits: the most negative input maps to 2^(RW-1).
            mag_d    = Result[RW-1] ? ((~Result) + RW'(1)) : Result;
            work_d   = '0;
            cnt_d    = '0;
        end else if (do_shift) begin
            work_d = {work_adj[4*ND-2:0], mag_q[RW-1]};
            mag_d  = {mag_q[RW-2:0], 1'b0};
            cnt_d  = cnt_q + CW'(1);
        end

        if (load_out) begin
            bcd_d     = err_c_q ? '0 : work_q;
            sign_d    = err_c_q ? 1'b0 : sign_c_q;
            err_out_d = err_c_q;
        end
    end

    // Datapath and result registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_prev_q <= 1'b0;
            sign_c_q     <= 1'b0;
            err_c_q      <= 1'b0;
            mag_q        <= '0;
            work_q       <= '0;
            cnt_q        <= '0;
            bcd_q        <= '0;
            sign_q       <= 1'b0;
            err_out_q    <= 1'b0;
            valid_q      <= 1'b0;
        end else begin
            ready_prev_q <= ready;
            sign_c_q     <= sign_c_d;
            err_c_q      <= err_c_d;
            mag_q        <= mag_d;
            work_q       <= work_d;
            cnt_q        <= cnt_d;
            bcd_q        <= bcd_d;
            sign_q       <= sign_d;
            err_out_q    <= err_out_d;
            valid_q      <= load_out;
        end
    end

    assign bcd       = bcd_q;
    assign sign      = sign_q;
    assign error_out = err_out_q;
    assign valid     = valid_q;
    assign dbg_state = state_q;

endmodule
